register: RTL and testbench



---
 rtl/register.sv | 27 ++
 tb/tb_register.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/register.sv
// Storage register with synchronous clear and write enable.
// Output is taken straight from the state flops.
module register #(
  parameter int unsigned WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             write_enable,
  input  logic [WIDTH-1:0] input_val,
  output logic [WIDTH-1:0] output_val
);

  // Initialiser gives a defined power-up value in simulation.
  logic [WIDTH-1:0] state = RESET_VALUE;

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= RESET_VALUE;
    end else if (write_enable) begin
      state <= input_val;
    end
  end

  assign output_val = state;

endmodule

// File: tb/tb_register.sv
// Self-checking bench for register: directed plan, vector table,
// mid-cycle pulses, randomized run against a reference model.
module tb_register;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        write_enable = 1'b0;
  logic [31:0] input_val = 32'h1;
  logic [31:0] output_val;

  logic        clear8 = 1'b0;
  logic        we8 = 1'b0;
  logic [7:0]  in8 = 8'h0;
  logic [7:0]  out8;

  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  register dut (
    .clk(clk),
    .clear(clear),
    .write_enable(write_enable),
    .input_val(input_val),
    .output_val(output_val)
  );

  register #(.WIDTH(8), .RESET_VALUE(8'h5A)) dut8 (
    .clk(clk),
    .clear(clear8),
    .write_enable(we8),
    .input_val(in8),
    .output_val(out8)
  );

  typedef struct {
    logic        c;
    logic        w;
    logic [31:0] v;
    logic [31:0] e;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic c, input logic w, input logic [31:0] v);
    clear = c;
    write_enable = w;
    input_val = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] model;
    logic        rc;
    logic        rw;
    logic [31:0] rv;

    tbl[0] = '{1'b0, 1'b1, 32'h12345678, 32'h12345678};
    tbl[1] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h12345678};
    tbl[2] = '{1'b1, 1'b0, 32'h00000000, 32'h00000000};
    tbl[3] = '{1'b0, 1'b0, 32'h00000ABC, 32'h00000000};
    tbl[4] = '{1'b0, 1'b1, 32'h80000000, 32'h80000000};
    tbl[5] = '{1'b1, 1'b1, 32'h00000001, 32'h00000000};
    tbl[6] = '{1'b1, 1'b0, 32'h00000002, 32'h00000000};
    tbl[7] = '{1'b0, 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF};
    tbl[8] = '{1'b0, 1'b0, 32'h00000000, 32'h7FFFFFFF};
    tbl[9] = '{1'b0, 1'b1, 32'h00000000, 32'h00000000};

    // 1. power-up hold (t=20)
    @(negedge clk);
    check("powerup_hold", output_val, 32'h0);
    check("powerup8", {24'h0, out8}, 32'h5A);

    // 2. single write
    write_enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("single_write", output_val, 32'h1);
    step(1'b0, 1'b0, 32'h1);
    check("write_hold", output_val, 32'h1);

    // 3. synchronous clear, unchanged before the edge
    clear = 1'b1;
    #5;
    check("clear_before_edge", output_val, 32'h1);
    @(posedge clk);
    @(negedge clk);
    check("clear_after_edge", output_val, 32'h0);

    // 4. clear priority
    step(1'b0, 1'b1, 32'h55);
    step(1'b1, 1'b1, 32'hDEADBEEF);
    check("clear_priority", output_val, 32'h0);

    // 5. hold against input changes
    step(1'b0, 1'b1, 32'hA5A5A5A5);
    check("write_a5", output_val, 32'hA5A5A5A5);
    step(1'b0, 1'b0, 32'hFFFFFFFF);
    step(1'b0, 1'b0, 32'h00000000);
    step(1'b0, 1'b0, 32'hFFFFFFFF);
    check("hold_vs_input", output_val, 32'hA5A5A5A5);

    // 6. back-to-back writes
    step(1'b0, 1'b1, 32'h1);
    check("b2b_1", output_val, 32'h1);
    step(1'b0, 1'b1, 32'h2);
    check("b2b_2", output_val, 32'h2);
    step(1'b0, 1'b1, 32'hFFFFFFFF);
    check("b2b_3", output_val, 32'hFFFFFFFF);

    // held clear keeps reset value
    step(1'b1, 1'b1, 32'h3);
    step(1'b1, 1'b0, 32'h4);
    step(1'b1, 1'b1, 32'h5);
    check("held_clear", output_val, 32'h0);

    // pulses strictly between edges have no effect
    step(1'b0, 1'b1, 32'h5);
    write_enable = 1'b0;
    #3 clear = 1'b1;
    #4 clear = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("clear_glitch", output_val, 32'h5);
    input_val = 32'h9;
    #3 write_enable = 1'b1;
    #4 write_enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("we_glitch", output_val, 32'h5);

    // vector table
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].c, tbl[i].w, tbl[i].v);
      check($sformatf("vec%0d", i), output_val, tbl[i].e);
    end

    // parameterised instance
    in8 = 8'h33;
    we8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("w8_write", {24'h0, out8}, 32'h33);
    we8 = 1'b1;
    clear8 = 1'b1;
    in8 = 8'hC3;
    @(posedge clk);
    @(negedge clk);
    check("w8_clear", {24'h0, out8}, 32'h5A);
    clear8 = 1'b0;
    we8 = 1'b0;

    // randomized run against a stored-value model
    model = output_val;
    for (int i = 0; i < 300; i++) begin
      rc = ($urandom_range(7) == 0);
      rw = ($urandom_range(1) == 1);
      rv = $urandom;
      step(rc, rw, rv);
      if (rc) model = 32'h0;
      else if (rw) model = rv;
      check($sformatf("rand%0d", i), output_val, model);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
